// File: rtl/button_debouncer.sv
//==============================================================================
// Module   : button_debouncer
// Brief    : Synchronises and debounces active-low pushbuttons into clean
//            active-high levels with one-cycle press/release strobes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_debouncer #(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] pmod,
  output logic [NUM_BTNS-1:0] btn_pressed,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_PRESSED      = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Chain carries the raw pin so reset to 1 equals the released idle level.
  logic [NUM_BTNS-1:0] meta_q;
  logic [NUM_BTNS-1:0] sync_q;
  logic [NUM_BTNS-1:0] sync_pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= pmod;
      sync_q <= meta_q;
    end
  end

  assign sync_pressed = ~sync_q;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 press_d, release_d;
    logic                 pressed_d;
    logic                 pressed_q, press_q, release_q;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        S_RELEASED: begin
          if (sync_pressed[i]) begin
            state_d = S_WAIT_PRESS;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        S_WAIT_PRESS: begin
          if (!sync_pressed[i]) begin
            state_d = S_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (!sync_pressed[i]) begin
            state_d = S_WAIT_RELEASE;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        S_WAIT_RELEASE: begin
          if (sync_pressed[i]) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    // Level is decoded from the next state so it moves on the transition edge.
    assign pressed_d = (state_d == S_PRESSED) || (state_d == S_WAIT_RELEASE);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= S_RELEASED;
        cnt_q     <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_pressed[i] = pressed_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    a_strobe_excl : assert property (@(posedge clk) !(press_q && release_q));
    a_cnt_bound   : assert property (@(posedge clk) cnt_q <= CNT_LAST);
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
//==============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed bench for button_debouncer with DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_button_debouncer;

  localparam int NUM_BTNS        = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_BTNS-1:0] pmod;
  logic [NUM_BTNS-1:0] btn_pressed;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;

  int total = 0;
  int bad   = 0;

  int press_cnt0 = 0;
  int press_cnt1 = 0;
  int rel_cnt0   = 0;
  int rel_cnt1   = 0;

  button_debouncer #(
    .NUM_BTNS        (NUM_BTNS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pmod        (pmod),
    .btn_pressed (btn_pressed),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (btn_press[0])   press_cnt0 = press_cnt0 + 1;
    if (btn_press[1])   press_cnt1 = press_cnt1 + 1;
    if (btn_release[0]) rel_cnt0   = rel_cnt0 + 1;
    if (btn_release[1]) rel_cnt1   = rel_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int p0_snap, p1_snap, r0_snap, r1_snap;

  initial begin
    rst  = 1'b1;
    pmod = 2'b00;
    step(3);
    chk("rst_pressed", 32'(btn_pressed), 32'h0);
    chk("rst_press",   32'(btn_press),   32'h0);
    chk("rst_release", 32'(btn_release), 32'h0);

    // Buttons held through reset are accepted 6 edges after rst falls.
    rst = 1'b0;
    step(5);
    chk("post_rst_e5_pressed", 32'(btn_pressed), 32'h0);
    step(1);
    chk("post_rst_e6_pressed", 32'(btn_pressed), 32'h3);
    chk("post_rst_e6_press",   32'(btn_press),   32'h3);
    step(1);
    chk("post_rst_e7_press",   32'(btn_press),   32'h0);
    chk("post_rst_e7_pressed", 32'(btn_pressed), 32'h3);

    pmod = 2'b11;
    step(5);
    chk("rel_both_e5_pressed", 32'(btn_pressed), 32'h3);
    step(1);
    chk("rel_both_e6_pressed", 32'(btn_pressed), 32'h0);
    chk("rel_both_e6_release", 32'(btn_release), 32'h3);
    chk("rel_both_e6_press",   32'(btn_press),   32'h0);
    step(1);
    chk("rel_both_e7_release", 32'(btn_release), 32'h0);

    // Clean press on channel 0 only.
    p1_snap = press_cnt1;
    pmod = 2'b10;
    step(5);
    chk("clean_e5_pressed", 32'(btn_pressed), 32'h0);
    step(1);
    chk("clean_e6_pressed", 32'(btn_pressed), 32'h1);
    chk("clean_e6_press",   32'(btn_press),   32'h1);
    step(1);
    chk("clean_e7_press",   32'(btn_press),   32'h0);
    chk("clean_e7_pressed", 32'(btn_pressed), 32'h1);
    chk("clean_ch1_quiet",  32'(press_cnt1 - p1_snap), 32'h0);

    // A 2-cycle release glitch is ignored.
    r0_snap = rel_cnt0;
    pmod = 2'b11;
    step(2);
    pmod = 2'b10;
    step(8);
    chk("rel_glitch_pressed", 32'(btn_pressed), 32'h1);
    chk("rel_glitch_strobes", 32'(rel_cnt0 - r0_snap), 32'h0);

    // Clean release of channel 0.
    r0_snap = rel_cnt0;
    pmod = 2'b11;
    step(5);
    chk("release_e5_pressed", 32'(btn_pressed), 32'h1);
    step(1);
    chk("release_e6_pressed", 32'(btn_pressed), 32'h0);
    chk("release_e6_release", 32'(btn_release), 32'h1);
    step(1);
    chk("release_e7_release", 32'(btn_release), 32'h0);
    chk("release_pulses",     32'(rel_cnt0 - r0_snap), 32'h1);

    // Bounce: 3 low, 1 high, 3 low, then high; gap lands on the accept edge.
    p0_snap = press_cnt0;
    pmod = 2'b10;
    step(3);
    pmod = 2'b11;
    step(1);
    pmod = 2'b10;
    step(3);
    pmod = 2'b11;
    step(10);
    chk("bounce_pressed", 32'(btn_pressed), 32'h0);
    chk("bounce_press",   32'(press_cnt0 - p0_snap), 32'h0);

    // Simultaneous press on both channels.
    pmod = 2'b00;
    step(5);
    chk("simul_e5_pressed", 32'(btn_pressed), 32'h0);
    step(1);
    chk("simul_e6_pressed", 32'(btn_pressed), 32'h3);
    chk("simul_e6_press",   32'(btn_press),   32'h3);
    chk("simul_e6_and",     32'(&btn_pressed), 32'h1);
    step(1);
    chk("simul_e7_press",   32'(btn_press),   32'h0);
    pmod = 2'b11;
    step(8);
    chk("simul_rel_pressed", 32'(btn_pressed), 32'h0);

    // Reset mid-count on channel 1: no strobe, re-accepted after reset.
    p1_snap = press_cnt1;
    pmod = 2'b01;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_pressed", 32'(btn_pressed), 32'h0);
    chk("midrst_press",   32'(press_cnt1 - p1_snap), 32'h0);
    step(5);
    chk("midrst_e5_pressed", 32'(btn_pressed), 32'h0);
    step(1);
    chk("midrst_e6_pressed", 32'(btn_pressed), 32'h2);
    chk("midrst_e6_press",   32'(btn_press),   32'h2);
    step(1);
    chk("midrst_e7_press",   32'(btn_press),   32'h0);
    chk("midrst_pulses",     32'(press_cnt1 - p1_snap), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
